bar_graph_engine: RTL

Parametrised successor to the fixed text renderer. Renders NUM_CHANNELS live data values as horizontal bar graphs on the 128x64 SSD1306 framebuffer, serving the screen driver's pixelAddress/pixelData read interface. Data enters through a valid/ready handshake and is committed only at frame boundaries, so frames never tear. Per-channel peak-hold markers decay over frames.

---
 rtl/bar_graph_engine.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/bar_graph_engine.sv
// bar_graph_engine
//
// Renders NUM_CHANNELS live values as horizontal bar graphs on a 128x64
// SSD1306-style framebuffer (8 pages x 128 columns, one byte per column per
// page). The screen driver presents a byte address on pixelAddress. The
// matching byte appears on pixelData one cycle later.
//
// Each channel owns one page. Its bar is lit in columns 0..len-1, where len is
// the top 7 bits of the channel value. New values are accepted through a
// valid/ready handshake and only become visible at a frame boundary, so a
// frame is always drawn from one consistent set of values.
//
// Optional feature (compile-time macro PEAK_HOLD_EN):
//   defined   -> per-channel peak-hold markers (8'hFF column) that decay by one
//                column every DECAY_FRAMES frames.
//   undefined -> no peak/decay logic; DECAY_FRAMES is ignored.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pixelAddress byte address from the screen driver: [9:7] page, [6:0] column
//   pixelData    registered byte for the address presented on the previous cycle
//   in_data      channel values, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid     in_data is valid
//   in_ready     block can accept in_data
//   frame_start  one-cycle pulse the cycle after each detected frame boundary
module bar_graph_engine #(
  parameter int         NUM_CHANNELS = 4,
  parameter int         DATA_WIDTH   = 8,
  parameter int         DECAY_FRAMES = 8,
  parameter logic [7:0] BAR_PATTERN  = 8'h7E
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [9:0]                         pixelAddress,
  output logic [7:0]                         pixelData,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic                               frame_start
);

  localparam int TotalWidth = NUM_CHANNELS * DATA_WIDTH;
  localparam int LenShift   = DATA_WIDTH - 7;

  logic [TotalWidth-1:0] display;
  logic [TotalWidth-1:0] displayNext;
  logic [TotalWidth-1:0] pending;
  logic                  pendingFull;
  logic                  pendingFullNext;
  logic [9:0]            prevAddr;
  logic                  boundary;
  logic                  transfer;
  logic [2:0]            page;
  logic [6:0]            column;
  logic [7:0]            pixelNext;
  logic [6:0]            lenNext [8];
  logic                  unusedDisplayBits;

  // A frame ends when the driver wraps from the last byte to the first.
  // prevAddr resets to 0, so the first address 0 after reset is not a boundary.
  assign boundary = (pixelAddress == 10'd0) && (prevAddr == 10'd1023);

  // Handshake: a word moves when in_valid && in_ready on a rising clk edge.
  // in_valid may stay high while in_ready is low; in_data is then ignored.
  // in_ready is low only while a word is pending and this is not a boundary
  // cycle. At a boundary the pending slot empties, so a new word is accepted
  // in the same cycle.
  assign in_ready = !pendingFull || boundary;
  assign transfer = in_valid && in_ready;

  // Commit logic. A word arriving on the boundary cycle goes straight to the
  // display and supersedes anything pending.
  always_comb begin
    displayNext     = display;
    pendingFullNext = pendingFull;
    if (boundary) begin
      pendingFullNext = 1'b0;
      if (transfer) begin
        displayNext = in_data;
      end else if (pendingFull) begin
        displayNext = pending;
      end
    end else if (transfer) begin
      pendingFullNext = 1'b1;
    end
  end

  // Bar lengths are sized for all 8 pages. Pages without a channel read as 0.
  for (genvar ch = 0; ch < 8; ch++) begin : gLen
    if (ch < NUM_CHANNELS) begin : gUsed
      assign lenNext[ch] = displayNext[ch*DATA_WIDTH + LenShift +: 7];
    end else begin : gUnused
      assign lenNext[ch] = 7'd0;
    end
  end

  // Only the top 7 bits of each value are drawn.
  assign unusedDisplayBits = ^displayNext;

`ifdef PEAK_HOLD_EN
  localparam int CntWidth = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  logic [CntWidth-1:0] decayCnt;
  logic                decayWrap;
  logic [6:0]          peak     [8];
  logic [6:0]          peakNext [8];

  assign decayWrap = (decayCnt == CntWidth'(DECAY_FRAMES - 1));

  // A channel whose peak rises this boundary skips decay for that boundary.
  always_comb begin
    for (int ch = 0; ch < 8; ch++) begin
      peakNext[ch] = peak[ch];
      if (boundary) begin
        if (lenNext[ch] > peak[ch]) begin
          peakNext[ch] = lenNext[ch];
        end else if (decayWrap && (peak[ch] != 7'd0)) begin
          peakNext[ch] = peak[ch] - 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decayCnt <= '0;
      for (int ch = 0; ch < 8; ch++) begin
        peak[ch] <= 7'd0;
      end
    end else begin
      if (boundary) begin
        decayCnt <= decayWrap ? '0 : decayCnt + CntWidth'(1);
      end
      for (int ch = 0; ch < 8; ch++) begin
        peak[ch] <= peakNext[ch];
      end
    end
  end
`else
  logic unusedDecayFrames;
  assign unusedDecayFrames = ^DECAY_FRAMES;
`endif

  assign page   = pixelAddress[9:7];
  assign column = pixelAddress[6:0];

  // Lookup uses the values being committed this cycle. At a boundary, the
  // first byte of the new frame already shows the new data.
  always_comb begin
    pixelNext = 8'h00;
    if (int'(page) < NUM_CHANNELS) begin
      if (column < lenNext[page]) begin
        pixelNext = BAR_PATTERN;
      end
`ifdef PEAK_HOLD_EN
      if ((peakNext[page] != 7'd0) && (column == peakNext[page])) begin
        pixelNext = 8'hFF;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display     <= '0;
      pending     <= '0;
      pendingFull <= 1'b0;
      prevAddr    <= 10'd0;
      pixelData   <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      display     <= displayNext;
      pendingFull <= pendingFullNext;
      if (transfer && !boundary) begin
        pending <= in_data;
      end
      prevAddr    <= pixelAddress;
      pixelData   <= pixelNext;
      frame_start <= boundary;
    end
  end

endmodule
